// File: rtl/gf2_poly_reduce_seq.sv
// Bit-serial GF(2) polynomial divider: reduces a wO-bit carry-less product
// modulo a monic degree-wI polynomial, one quotient bit per clock.
module gf2_poly_reduce_seq #(
    parameter int wI = 32,
    parameter int wO = 2 * wI
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iValid,
    output logic          oReady,
    input  logic [wO-1:0] iDividend,
    input  logic [wI-1:0] iPoly,
    output logic          oValid,
    input  logic          iReady,
    output logic [wI-1:0] oQuot,
    output logic [wI-1:0] oRem,
    output logic [1:0]    oState
);

    localparam int CW = (wI > 1) ? $clog2(wI) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [wO-1:0]   r_q;
    logic [wO-1:0]   r_x;
    logic [wI:0]     p_q;
    logic [wI-1:0]   q_q;
    logic [CW-1:0]   cnt_q;
    logic            last_iter;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Input side: oReady is high only in IDLE. Output side: oValid is high
    // only in DONE and the result holds steady until iReady is seen.
    assign oReady    = (state_q == IDLE);
    assign oValid    = (state_q == DONE);
    assign oQuot     = q_q;
    assign oRem      = r_q[wO-1 -: wI];
    assign oState    = state_q;
    assign last_iter = (cnt_q == CW'(wI - 1));

    // Leading coefficient set: cancel it with the monic modulus before shifting.
    always_comb begin
        r_x = r_q;
        if (r_q[wO-1]) begin
            r_x[wO-1 -: wI+1] = r_q[wO-1 -: wI+1] ^ p_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iValid) state_d = BUSY;
            BUSY:    if (last_iter) state_d = DONE;
            DONE:    if (iReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_q   <= '0;
            p_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iValid) begin
                        r_q   <= iDividend;
                        p_q   <= {1'b1, iPoly};
                        q_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                BUSY: begin
                    r_q   <= r_x << 1;
                    q_q   <= {q_q[wI-2:0], r_q[wO-1]};
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2_poly_reduce_seq.sv
// Directed bench for gf2_poly_reduce_seq: wI=8 and wI=32 instances, plus
// random wI=32 divisions checked by carry-less multiply-back.
module tb_gf2_poly_reduce_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // wI = 8 instance
    logic        v8_in, rdy8_out, v8_out, rdy8_in;
    logic [15:0] d8;
    logic [7:0]  p8, q8, r8;
    logic [1:0]  s8;

    // wI = 32 instance
    logic        v32_in, rdy32_out, v32_out, rdy32_in;
    logic [63:0] d32;
    logic [31:0] p32, q32, r32;
    logic [1:0]  s32;

    int n_tests = 0;
    int n_fail  = 0;

    gf2_poly_reduce_seq #(.wI(8), .wO(16)) u8 (
        .iClk(clk), .iRst(rst), .iValid(v8_in), .oReady(rdy8_out),
        .iDividend(d8), .iPoly(p8), .oValid(v8_out), .iReady(rdy8_in),
        .oQuot(q8), .oRem(r8), .oState(s8)
    );

    gf2_poly_reduce_seq #(.wI(32), .wO(64)) u32 (
        .iClk(clk), .iRst(rst), .iValid(v32_in), .oReady(rdy32_out),
        .iDividend(d32), .iPoly(p32), .oValid(v32_out), .iReady(rdy32_in),
        .oQuot(q32), .oRem(r32), .oState(s32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] clmul(input logic [31:0] a, input logic [32:0] b);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) acc = acc ^ (64'(b) << i);
        end
        return acc;
    endfunction

    // Presents one request; returns after the accepting edge (+1 time unit).
    task automatic req8(input logic [15:0] d, input logic [7:0] p);
        int n;
        n = 0;
        while (!rdy8_out && n < 100) begin tick(); n++; end
        if (n >= 100) check("req8_ready_timeout", 1'b0, 1'b1);
        v8_in = 1'b1; d8 = d; p8 = p;
        tick();
        v8_in = 1'b0;
    endtask

    task automatic req32(input logic [63:0] d, input logic [31:0] p);
        int n;
        n = 0;
        while (!rdy32_out && n < 100) begin tick(); n++; end
        if (n >= 100) check("req32_ready_timeout", 1'b0, 1'b1);
        v32_in = 1'b1; d32 = d; p32 = p;
        tick();
        v32_in = 1'b0;
    endtask

    // Counts edges until oValid; an expired budget is a failed comparison.
    task automatic wait_valid(input bit wide, output int n);
        n = 0;
        while (!(wide ? v32_out : v8_out) && n < 100) begin tick(); n++; end
        if (n >= 100) check(wide ? "valid32_timeout" : "valid8_timeout", 1'b0, 1'b1);
    endtask

    task automatic pop(input bit wide);
        if (wide) rdy32_in = 1'b1; else rdy8_in = 1'b1;
        tick();
        rdy32_in = 1'b0; rdy8_in = 1'b0;
    endtask

    initial begin
        int lat;
        logic [7:0]  hq, hr;
        logic [63:0] dd;
        logic [31:0] pp;

        rst = 1'b1;
        v8_in = 0; rdy8_in = 0; d8 = '0; p8 = '0;
        v32_in = 0; rdy32_in = 0; d32 = '0; p32 = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_ready", rdy8_out, 1'b1);
        check("rst_valid", v8_out, 1'b0);
        check("rst_quot", q8, 8'h00);
        check("rst_rem", r8, 8'h00);
        check("rst_state", s8, 2'd0);

        // AES reduction; iPoly changes after accept must not matter
        req8(16'h2B79, 8'h1B);
        p8 = 8'hFF;
        check("busy_ready_low", rdy8_out, 1'b0);
        wait_valid(1'b0, lat);
        check("aes_latency", lat, 8);
        check("aes_quot", q8, 8'h28);
        check("aes_rem", r8, 8'hC1);
        pop(1'b0);
        check("aes_pop_valid", v8_out, 1'b0);
        check("aes_pop_ready", rdy8_out, 1'b1);

        // x^8 mod AES poly
        req8(16'h0100, 8'h1B);
        wait_valid(1'b0, lat);
        check("x8_quot", q8, 8'h01);
        check("x8_rem", r8, 8'h1B);
        pop(1'b0);

        // Dividend already reduced
        req8(16'h00A5, 8'h5C);
        wait_valid(1'b0, lat);
        check("small_quot", q8, 8'h00);
        check("small_rem", r8, 8'hA5);
        pop(1'b0);

        // Zero dividend
        req8(16'h0000, 8'h1B);
        wait_valid(1'b0, lat);
        check("zero_quot", q8, 8'h00);
        check("zero_rem", r8, 8'h00);
        pop(1'b0);

        // Modulus x^8: plain split of the dividend
        req8(16'hABCD, 8'h00);
        wait_valid(1'b0, lat);
        check("xn_quot", q8, 8'hAB);
        check("xn_rem", r8, 8'hCD);
        pop(1'b0);

        // Backpressure in DONE with ignored iValid pulses
        req8(16'h2B79, 8'h1B);
        wait_valid(1'b0, lat);
        hq = q8; hr = r8;
        check("bp_first_quot", hq, 8'h28);
        for (int i = 0; i < 5; i++) begin
            v8_in = i[0]; d8 = 16'h1234 + 16'(i); p8 = 8'(i);
            tick();
            check("bp_valid", v8_out, 1'b1);
            check("bp_ready", rdy8_out, 1'b0);
            check("bp_quot", q8, 8'h28);
            check("bp_rem", r8, 8'hC1);
        end
        v8_in = 1'b0;
        pop(1'b0);
        check("bp_idle_ready", rdy8_out, 1'b1);
        check("bp_idle_valid", v8_out, 1'b0);
        req8(16'h0100, 8'h1B);
        wait_valid(1'b0, lat);
        check("bp_next_latency", lat, 8);
        check("bp_next_quot", q8, 8'h01);
        check("bp_next_rem", r8, 8'h1B);
        pop(1'b0);

        // Reset mid-BUSY
        req8(16'h2B79, 8'h1B);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", v8_out, 1'b0);
        check("mid_rst_ready", rdy8_out, 1'b1);
        check("mid_rst_quot", q8, 8'h00);
        check("mid_rst_rem", r8, 8'h00);
        req8(16'h2B79, 8'h1B);
        wait_valid(1'b0, lat);
        check("post_rst_quot", q8, 8'h28);
        check("post_rst_rem", r8, 8'hC1);
        pop(1'b0);

        // wI = 32 directed
        req32(64'h0000_0001_0000_0000, 32'h0000_008D);
        wait_valid(1'b1, lat);
        check("w32_latency", lat, 32);
        check("w32_quot", q32, 32'h1);
        check("w32_rem", r32, 32'h8D);
        pop(1'b1);

        // wI = 32 random, checked by multiplying back
        for (int k = 0; k < 1000; k++) begin
            dd = {$urandom(), $urandom()};
            pp = $urandom();
            req32(dd, pp);
            wait_valid(1'b1, lat);
            check("w32_rand", clmul(q32, {1'b1, pp}) ^ 64'(r32), dd);
            pop(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
